// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN         = 32;
  localparam int MULDIV_ITERS = XLEN;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring divide step.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic         is_div,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] operand,
  output logic [W-1:0] hi_next,
  output logic [W-1:0] lo_next
);

  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic [W-1:0] sub;
  logic         ge;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    shifted = {hi, lo[W-1]};
    ge      = shifted >= {1'b0, operand};
    // Partial remainder stays below the divisor, so the difference fits in W bits.
    sub     = shifted[W-1:0] - operand;
    if (is_div) begin
      hi_next = ge ? sub : shifted[W-1:0];
      lo_next = {lo[W-2:0], ge};
    end else begin
      hi_next = sum[W:1];
      lo_next = {sum[0], lo[W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide in EX; stalls ID/EX until the result is ready.
// state | meaning: IDLE wait for start | CALC one iteration per cycle | DONE result valid, release stall
module ex_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(MULDIV_ITERS);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e state, state_nxt;
  muldiv_op_e    op_in, op_q;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   acc_hi, acc_lo, operand, step_hi, step_lo;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, fixed_res;
  logic [2*XLEN-1:0] prod, prod_s;
  logic sign_a, sign_b, sa_in, sb_in, signed_a, signed_b;
  logic accept, div_zero, div_ovf, special, last, calc_div;

  assign op_in    = muldiv_op_e'(funct3);
  assign accept   = (state == IDLE) && start && !flush;
  assign last     = (count == CW'(MULDIV_ITERS - 1));
  assign calc_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  always_comb begin
    signed_a    = !(op_in inside {OP_MULHU, OP_DIVU, OP_REMU});
    signed_b    = signed_a && (op_in != OP_MULHSU);
    sa_in       = signed_a & op_a[XLEN-1];
    sb_in       = signed_b & op_b[XLEN-1];
    a_mag       = sa_in ? -op_a : op_a;
    b_mag       = sb_in ? -op_b : op_b;
    div_zero    = funct3[2] && (op_b == '0);
    div_ovf     = (op_in inside {OP_DIV, OP_REM}) && (op_a == INT_MIN) && (op_b == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? op_a : '1;
    else
      special_res = funct3[1] ? '0 : INT_MIN;
  end

  muldiv_step #(.W(XLEN)) u_step (
    .is_div  (calc_div),
    .hi      (acc_hi),
    .lo      (acc_lo),
    .operand (operand),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Magnitudes were iterated; restore signs on the final step outputs.
  always_comb begin
    prod      = {step_hi, step_lo};
    prod_s    = (sign_a ^ sign_b) ? -prod : prod;
    fixed_res = '0;
    case (op_q)
      OP_MUL:                       fixed_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fixed_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fixed_res = (sign_a ^ sign_b) ? -step_lo : step_lo;
      default:                      fixed_res = sign_a ? -step_hi : step_hi;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    stall = start && !flush;
      CALC:    stall = !flush;
      DONE:    done  = 1'b1;
      default: ;
    endcase
    if (!reset_n) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      op_q    <= OP_MUL;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      result  <= '0;
    end else if (accept) begin
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= funct3[2] ? a_mag : b_mag;
      operand <= funct3[2] ? b_mag : a_mag;
      op_q    <= op_in;
      sign_a  <= sa_in;
      sign_b  <= sb_in;
      if (special) result <= special_res;
    end else if ((state == CALC) && !flush) begin
      count  <= count + 1'b1;
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (last) result <= fixed_res;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit against a plain-arithmetic RV32M reference.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [5:0]  lat;
  } vec_t;

  vec_t dir_tbl [12];

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .flush   (flush),
    .stall   (stall),
    .done    (done),
    .result  (result)
  );

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op with start held until done; operands are scrambled once latched.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int stall_err);
    res = '0;
    lat = -1;
    stall_err = 0;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    for (int c = 0; c < 60 && lat < 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        res = result;
        if (stall !== 1'b0) stall_err++;
        start = 1'b0;
      end else begin
        if (stall !== 1'b1) stall_err++;
        if (c >= 1) begin
          funct3 = 3'($urandom);
          op_a   = $urandom;
          op_b   = $urandom;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; flush = 1'b0;
    funct3 = 3'd0; op_a = 32'd7; op_b = 32'd6;
    #12;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++;
    if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h want 0", result); end
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_outputs: got stall=%b done=%b want 0 0", stall, done);
    end
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int lat, serr;
    dir_tbl = '{
      '{3'd0, 32'd7,          32'd6,          32'd42,         6'd33},
      '{3'd1, 32'h8000_0000,  32'd2,          32'hFFFF_FFFF,  6'd33},
      '{3'd3, 32'h8000_0000,  32'd2,          32'h0000_0001,  6'd33},
      '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  6'd33},
      '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  6'd33},
      '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  6'd33},
      '{3'd5, 32'd100,        32'd7,          32'd14,         6'd33},
      '{3'd7, 32'd100,        32'd7,          32'd2,          6'd33},
      '{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF,  6'd1},
      '{3'd6, 32'd5,          32'd0,          32'd5,          6'd1},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  6'd1},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          6'd1}
    };
    for (int i = 0; i < 12; i++) begin
      do_op(dir_tbl[i].f, dir_tbl[i].a, dir_tbl[i].b, res, lat, serr);
      vectors++;
      if (res !== dir_tbl[i].exp) begin
        miscompares++;
        $display("FAIL directed[%0d]_result: got %h want %h", i, res, dir_tbl[i].exp);
      end
      vectors++;
      if (lat !== int'(dir_tbl[i].lat)) begin
        miscompares++;
        $display("FAIL directed[%0d]_latency: got %0d want %0d", i, lat, dir_tbl[i].lat);
      end
      vectors++;
      if (serr !== 0) begin
        miscompares++;
        $display("FAIL directed[%0d]_stall: got %0d bad cycles want 0", i, serr);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] res, a, b;
    logic [2:0] f;
    int lat, serr;
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom);
      a = pick_operand();
      b = pick_operand();
      do_op(f, a, b, res, lat, serr);
      vectors++;
      if (res !== ref_result(f, a, b)) begin
        miscompares++;
        $display("FAIL random[%0d]_result f=%0d a=%h b=%h: got %h want %h",
                 i, f, a, b, res, ref_result(f, a, b));
      end
      vectors++;
      if (lat !== ref_lat(f, a, b)) begin
        miscompares++;
        $display("FAIL random[%0d]_latency f=%0d: got %0d want %0d", i, f, lat, ref_lat(f, a, b));
      end
      vectors++;
      if (serr !== 0) begin
        miscompares++;
        $display("FAIL random[%0d]_stall: got %0d bad cycles want 0", i, serr);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat, serr, ndone;
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    vectors++;
    if (ndone !== 0) begin miscompares++; $display("FAIL flush_no_done: got %0d pulses want 0", ndone); end
    do_op(3'd5, 32'd1000, 32'd7, res, lat, serr);
    vectors++;
    if (res !== 32'd142) begin miscompares++; $display("FAIL flush_restart_result: got %h want %h", res, 32'd142); end
    vectors++;
    if (lat !== 33) begin miscompares++; $display("FAIL flush_restart_latency: got %0d want 33", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, r1, r2;
    int ndone, d1, d2;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = 32'($urandom_range(1, 32'h00FF_FFFF));
    ndone = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0;
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd0; op_a = a1; op_b = b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          d1 = c; r1 = result;
          funct3 = 3'd5; op_a = a2; op_b = b2;
        end else if (ndone == 2) begin
          d2 = c; r2 = result;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (ndone !== 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
    vectors++;
    if (d1 !== 33) begin miscompares++; $display("FAIL b2b_first_latency: got %0d want 33", d1); end
    vectors++;
    if (d2 !== 67) begin miscompares++; $display("FAIL b2b_second_latency: got %0d want 67", d2); end
    vectors++;
    if (r1 !== ref_result(3'd0, a1, b1)) begin
      miscompares++; $display("FAIL b2b_mul_result: got %h want %h", r1, ref_result(3'd0, a1, b1));
    end
    vectors++;
    if (r2 !== ref_result(3'd5, a2, b2)) begin
      miscompares++; $display("FAIL b2b_divu_result: got %h want %h", r2, ref_result(3'd5, a2, b2));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res, a, b;
    int lat, serr, ndone;
    do_op(3'd0, 32'd7, 32'd6, res, lat, serr);
    vectors++;
    if (res !== 32'd42) begin miscompares++; $display("FAIL pre_reset_result: got %h want %h", res, 32'd42); end
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd0; op_a = $urandom; op_b = $urandom;
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL midreset_stall: got %b want 0", stall); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL midreset_done: got %b want 0", done); end
    vectors++;
    if (result !== 32'h0) begin miscompares++; $display("FAIL midreset_result: got %h want 0", result); end
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    vectors++;
    if (ndone !== 0) begin miscompares++; $display("FAIL midreset_no_done: got %0d pulses want 0", ndone); end
    a = $urandom; b = $urandom;
    do_op(3'd1, a, b, res, lat, serr);
    vectors++;
    if (res !== ref_result(3'd1, a, b)) begin
      miscompares++; $display("FAIL post_reset_result: got %h want %h", res, ref_result(3'd1, a, b));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
